reg_ctx_engine: RTL and testbench

Sequencer that initiates register file traffic to save and restore the whole register context. Save mode reads every register through the register file read port and stores it to data memory at base_addr+i. Restore mode reads data memory and writes each value back through the register file write port. Sits beside the control unit and is used on context switch, interrupt entry and interrupt exit; the core pipeline is stalled while busy is high.

---
 rtl/reg_ctx_engine.sv | 115 +++++++++++
 tb/tb_reg_ctx_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctx_engine.sv
// Register-context save/restore sequencer: walks the register file and
// streams it to data memory (save) or back from data memory (restore).
module reg_ctx_engine #(
   parameter int NUM_REGS = 8,
   parameter int REG_AW   = 3,
   parameter int DW       = 8,
   parameter int AW       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [AW-1:0]     base_addr,
   output logic              busy,
   output logic              done,
   output logic [REG_AW-1:0] rf_src,
   output logic              rf_read_en,
   input  logic [DW-1:0]     rf_rdata,
   output logic [REG_AW-1:0] rf_dest,
   output logic [DW-1:0]     rf_wdata,
   output logic              rf_write_en,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic              mem_write_en,
   input  logic [DW-1:0]     mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      SAVE,
      RESTORE,
      DONE
   } state_t;

   localparam logic [REG_AW:0] LAST_SAVE = (REG_AW+1)'(NUM_REGS - 1);
   localparam logic [REG_AW:0] LAST_RST  = (REG_AW+1)'(NUM_REGS);

   state_t          state, state_nx;
   logic [REG_AW:0] idx, idx_nx;
   logic [AW-1:0]   base, base_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         base  <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         base  <= base_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      base_nx      = base;
      busy         = 1'b0;
      done         = 1'b0;
      rf_src       = '0;
      rf_read_en   = 1'b0;
      rf_dest      = '0;
      rf_wdata     = '0;
      rf_write_en  = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_write_en = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               base_nx  = base_addr;
               idx_nx   = '0;
               state_nx = mode ? RESTORE : SAVE;
            end
         end
         SAVE: begin
            busy         = 1'b1;
            rf_src       = REG_AW'(idx);
            rf_read_en   = 1'b1;
            mem_addr     = base + AW'(idx);
            mem_wdata    = rf_rdata;
            mem_write_en = 1'b1;
            idx_nx       = idx + 1'b1;
            if (idx == LAST_SAVE) begin
               state_nx = DONE;
            end
         end
         RESTORE: begin
            busy = 1'b1;
            if (idx < LAST_RST) begin
               mem_addr = base + AW'(idx);
            end
            // memory data lags its address by a cycle, so writes trail by one index
            if (idx != '0) begin
               rf_dest     = REG_AW'(idx - 1'b1);
               rf_wdata    = mem_rdata;
               rf_write_en = 1'b1;
            end
            idx_nx = idx + 1'b1;
            if (idx == LAST_RST) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            idx_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with a behavioural register file
// and a one-cycle-latency data memory.
module tb_reg_ctx_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       mode;
   logic [7:0] base_addr;
   logic       busy, done;
   logic [2:0] rf_src, rf_dest;
   logic       rf_read_en, rf_write_en, mem_write_en;
   logic [7:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata;

   logic [7:0] rf [8];
   logic [7:0] mem [256];

   logic       bd_rf_we, bd_mem_we;
   logic [2:0] bd_rf_idx;
   logic [7:0] bd_mem_addr, bd_val;

   int n_chk = 0;
   int n_fail = 0;

   logic [34:0] outs;
   assign outs = {busy, done, rf_read_en, rf_write_en, mem_write_en,
                  rf_src, rf_dest, rf_wdata, mem_addr, mem_wdata};

   always #5 clk = ~clk;

   reg_ctx_engine #(.NUM_REGS(8), .REG_AW(3), .DW(8), .AW(8)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .mode(mode),
      .base_addr(base_addr),
      .busy(busy),
      .done(done),
      .rf_src(rf_src),
      .rf_read_en(rf_read_en),
      .rf_rdata(rf_rdata),
      .rf_dest(rf_dest),
      .rf_wdata(rf_wdata),
      .rf_write_en(rf_write_en),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_write_en(mem_write_en),
      .mem_rdata(mem_rdata)
   );

   assign rf_rdata = rf[rf_src];

   always @(posedge clk) begin
      if (rf_write_en) rf[rf_dest] <= rf_wdata;
      if (bd_rf_we) rf[bd_rf_idx] <= bd_val;
      if (mem_write_en) mem[mem_addr] <= mem_wdata;
      if (bd_mem_we) mem[bd_mem_addr] <= bd_val;
      mem_rdata <= mem[mem_addr];
   end

   task automatic load_rf(input logic [2:0] i, input logic [7:0] v);
      bd_rf_we = 1'b1; bd_rf_idx = i; bd_val = v;
      @(negedge clk);
      bd_rf_we = 1'b0;
   endtask

   task automatic load_mem(input logic [7:0] a, input logic [7:0] v);
      bd_mem_we = 1'b1; bd_mem_addr = a; bd_val = v;
      @(negedge clk);
      bd_mem_we = 1'b0;
   endtask

   // Runs one operation from IDLE; returns at the negedge after done.
   task automatic op(input logic m, input logic [7:0] b,
                     input int inj, input bit inj_done,
                     output int nb, output int done_at, output int nd,
                     output int bad, output int first_we);
      nb = 0; done_at = -1; nd = 0; bad = 0; first_we = 0;
      start = 1'b1; mode = m; base_addr = b;
      @(negedge clk);
      start = 1'b0; mode = ~m; base_addr = 8'h33;
      for (int i = 0; i < 20; i++) begin
         if (busy) nb++;
         if (i == 0) first_we = int'(rf_write_en);
         if ((!m && rf_write_en) || (m && mem_write_en)) bad++;
         if (done) begin
            nd++;
            done_at = i;
            start = inj_done;
            @(negedge clk);
            start = 1'b0;
            break;
         end
         start = (i == inj);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = 8'h00;
      bd_rf_we = 1'b0; bd_mem_we = 1'b0;
      bd_rf_idx = '0; bd_mem_addr = '0; bd_val = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outs got=%h want=0", outs);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (outs !== '0) begin
            n_fail++;
            $display("FAIL idle_outs cyc=%0d got=%h want=0", i, outs);
         end
      end
   endtask

   task automatic test_save;
      int nb, da, nd, bad, fw;
      for (int i = 0; i < 8; i++) load_rf(3'(i), 8'(8'h10 + i));
      op(1'b0, 8'h40, -1, 1'b0, nb, da, nd, bad, fw);
      n_chk++;
      if (nb !== 8 || nd !== 1 || da !== 8 || bad !== 0) begin
         n_fail++;
         $display("FAIL save_timing busy=%0d done=%0d at=%0d bad=%0d want 8/1/8/0",
                  nb, nd, da, bad);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (mem[8'h40 + i] !== 8'(8'h10 + i)) begin
            n_fail++;
            $display("FAIL save_mem[%0d] got=%h want=%h", i, mem[8'h40 + i], 8'(8'h10 + i));
         end
      end
   endtask

   task automatic test_restore;
      int nb, da, nd, bad, fw;
      for (int i = 0; i < 8; i++) load_mem(8'(8'h80 + i), 8'(8'hA0 + i));
      op(1'b1, 8'h80, -1, 1'b0, nb, da, nd, bad, fw);
      n_chk++;
      if (nb !== 9 || nd !== 1 || da !== 9 || bad !== 0 || fw !== 0) begin
         n_fail++;
         $display("FAIL restore_timing busy=%0d done=%0d at=%0d bad=%0d fw=%0d want 9/1/9/0/0",
                  nb, nd, da, bad, fw);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (rf[i] !== 8'(8'hA0 + i)) begin
            n_fail++;
            $display("FAIL restore_rf[%0d] got=%h want=%h", i, rf[i], 8'(8'hA0 + i));
         end
      end
   endtask

   task automatic test_wrap;
      int nb, da, nd, bad, fw;
      logic [7:0] a;
      op(1'b0, 8'hFC, -1, 1'b0, nb, da, nd, bad, fw);
      n_chk++;
      if (nb !== 8 || nd !== 1) begin
         n_fail++;
         $display("FAIL wrap_timing busy=%0d done=%0d want 8/1", nb, nd);
      end
      for (int i = 0; i < 8; i++) begin
         a = 8'(8'hFC + i);
         n_chk++;
         if (mem[a] !== 8'(8'hA0 + i)) begin
            n_fail++;
            $display("FAIL wrap_mem[%h] got=%h want=%h", a, mem[a], 8'(8'hA0 + i));
         end
      end
   endtask

   task automatic test_back_to_back;
      int nb, da, nd, bad, fw;
      op(1'b0, 8'h20, 2, 1'b1, nb, da, nd, bad, fw);
      n_chk++;
      if (nb !== 8 || nd !== 1 || da !== 8 || bad !== 0) begin
         n_fail++;
         $display("FAIL ignore_start busy=%0d done=%0d at=%0d bad=%0d want 8/1/8/0",
                  nb, nd, da, bad);
      end
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done busy=%b done=%b want 0/0", busy, done);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (mem[8'h20 + i] !== 8'(8'hA0 + i)) begin
            n_fail++;
            $display("FAIL ignore_mem[%0d] got=%h want=%h", i, mem[8'h20 + i], 8'(8'hA0 + i));
         end
      end
      op(1'b1, 8'h40, -1, 1'b0, nb, da, nd, bad, fw);
      n_chk++;
      if (nb !== 9 || nd !== 1 || da !== 9 || bad !== 0) begin
         n_fail++;
         $display("FAIL b2b_timing busy=%0d done=%0d at=%0d bad=%0d want 9/1/9/0",
                  nb, nd, da, bad);
      end
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (rf[i] !== 8'(8'h10 + i)) begin
            n_fail++;
            $display("FAIL b2b_rf[%0d] got=%h want=%h", i, rf[i], 8'(8'h10 + i));
         end
      end
   endtask

   task automatic test_reset_mid_restore;
      logic [7:0] exp;
      int nd;
      nd = 0;
      for (int i = 0; i < 8; i++) load_mem(8'(8'h90 + i), 8'(8'h50 + i));
      start = 1'b1; mode = 1'b1; base_addr = 8'h90;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         if (done) nd++;
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL midreset_outs got=%h want=0", outs);
      end
      repeat (2) begin
         @(negedge clk);
         if (done) nd++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      n_chk++;
      if (nd !== 0) begin
         n_fail++;
         $display("FAIL midreset_done got=%0d want=0", nd);
      end
      for (int i = 0; i < 8; i++) begin
         exp = (i < 2) ? 8'(8'h50 + i) : 8'(8'h10 + i);
         n_chk++;
         if (rf[i] !== exp) begin
            n_fail++;
            $display("FAIL midreset_rf[%0d] got=%h want=%h", i, rf[i], exp);
         end
      end
   endtask

   initial begin
      test_reset;
      test_save;
      test_restore;
      test_wrap;
      test_back_to_back;
      test_reset_mid_restore;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
